// File: rtl/sw_target_feeder.sv
// sw_target_feeder: FIFO-buffered feeder that streams target bases into the left edge of the SW PE array.
// Define SW_FEED_STATS_EN to add the o_seq_count / o_underrun_count statistics outputs.
module sw_target_feeder #(
  parameter int unsigned LENGTH     = 48,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned LOG_DEPTH  = 6,
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [1:0]           s_base,
  input  logic                 s_last,
  output logic                 o_rst,
  output logic                 o_en,
  output logic [1:0]           o_data,
  output logic                 o_busy,
  output logic                 o_seq_done,
  output logic [LEN_WIDTH-1:0] o_seq_len,
  output logic                 o_underrun
`ifdef SW_FEED_STATS_EN
  ,
  output logic [15:0]          o_seq_count,
  output logic [15:0]          o_underrun_count
`endif
);

  localparam int unsigned CNT_W = LOG_DEPTH + 1;
  localparam int unsigned TMR_W = $clog2(LENGTH + CLR_CYCLES + 2);

  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_STREAM, ST_DISCARD, ST_DRAIN} state_e;

  state_e               state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [2:0]           mem_q [FIFO_DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d, pend_q, pend_d;
  logic                 ready_q;
  logic                 rst_q, rst_d, en_q, en_d, busy_q, done_q, done_d, und_q, und_d;
  logic [1:0]           data_q, data_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 push_c, pop_c, full_c, empty_c, head_last_c;
  logic [1:0]           head_base_c;

  assign full_c      = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty_c     = (cnt_q == '0);
  assign push_c      = s_valid & ready_q;
  assign head_last_c = mem_q[rd_ptr_q][2];
  assign head_base_c = mem_q[rd_ptr_q][1:0];
  assign cnt_d       = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
  // pend tracks complete sequences held in the FIFO
  assign pend_d      = pend_q + CNT_W'(push_c & s_last) - CNT_W'(pop_c & head_last_c);

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= {s_last, s_base};
  end

  // Next state; every output is registered one cycle behind the state that produces it
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pop_c   = 1'b0;
    rst_d   = 1'b0;
    en_d    = 1'b0;
    data_d  = 2'b00;
    done_d  = 1'b0;
    len_d   = len_q;
    und_d   = und_q;
    case (state_q)
      ST_IDLE: begin
        if ((pend_q != '0) || full_c) begin
          state_d = ST_CLEAR;
          tmr_d   = '0;
          len_d   = '0;
          und_d   = 1'b0;
        end
      end
      ST_CLEAR: begin
        rst_d = 1'b1;
        if (tmr_q == TMR_W'(CLR_CYCLES - 1)) begin
          state_d = ST_STREAM;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_STREAM: begin
        if (!empty_c) begin
          pop_c  = 1'b1;
          en_d   = 1'b1;
          data_d = head_base_c;
          if (!(&len_q)) len_d = len_q + LEN_WIDTH'(1);
          if (head_last_c) begin
            state_d = ST_DRAIN;
            tmr_d   = '0;
          end
        end else begin
          und_d   = 1'b1;
          state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (!empty_c) begin
          pop_c = 1'b1;
          if (head_last_c) begin
            state_d = ST_DRAIN;
            tmr_d   = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (tmr_q == TMR_W'(LENGTH)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      ready_q  <= 1'b0;
      rst_q    <= 1'b0;
      en_q     <= 1'b0;
      data_q   <= 2'b00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      len_q    <= '0;
      und_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + LOG_DEPTH'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + LOG_DEPTH'(1);
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      ready_q  <= (cnt_d != CNT_W'(FIFO_DEPTH));
      rst_q    <= rst_d;
      en_q     <= en_d;
      data_q   <= data_d;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= done_d;
      len_q    <= len_d;
      und_q    <= und_d;
    end
  end

  assign s_ready    = ready_q;
  assign o_rst      = rst_q;
  assign o_en       = en_q;
  assign o_data     = data_q;
  assign o_busy     = busy_q;
  assign o_seq_done = done_q;
  assign o_seq_len  = len_q;
  assign o_underrun = und_q;

`ifdef SW_FEED_STATS_EN
  logic [15:0] seq_cnt_q, und_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_cnt_q <= '0;
      und_cnt_q <= '0;
    end else begin
      if (done_d) seq_cnt_q <= seq_cnt_q + 16'(1);
      if ((state_q == ST_STREAM) && (state_d == ST_DISCARD)) und_cnt_q <= und_cnt_q + 16'(1);
    end
  end

  assign o_seq_count      = seq_cnt_q;
  assign o_underrun_count = und_cnt_q;
`endif

endmodule

// File: tb/tb_sw_target_feeder.sv
// tb_sw_target_feeder: directed and randomized checks of sw_target_feeder against a queue-based model
// of the expected base stream, per-sequence lengths and drain timing.
`timescale 1ns/1ps
module tb_sw_target_feeder;

  localparam int DRAIN_GAP = 49;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [1:0]  s_base;
  logic        s_last;
  logic        o_rst;
  logic        o_en;
  logic [1:0]  o_data;
  logic        o_busy;
  logic        o_seq_done;
  logic [15:0] o_seq_len;
  logic        o_underrun;
`ifdef SW_FEED_STATS_EN
  logic [15:0] o_seq_count;
  logic [15:0] o_underrun_count;
`endif

  sw_target_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_base     (s_base),
    .s_last     (s_last),
    .o_rst      (o_rst),
    .o_en       (o_en),
    .o_data     (o_data),
    .o_busy     (o_busy),
    .o_seq_done (o_seq_done),
    .o_seq_len  (o_seq_len),
    .o_underrun (o_underrun)
`ifdef SW_FEED_STATS_EN
    ,
    .o_seq_count      (o_seq_count),
    .o_underrun_count (o_underrun_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  int unsigned viol  = 0;
  int unsigned stall = 0;

  // Observed array-side events
  logic [1:0]  en_data[$];
  int unsigned en_cyc[$];
  int unsigned rst_cyc[$];
  int unsigned done_cyc[$];
  int unsigned done_len[$];
  logic        done_und[$];

  // Reference model: bases expected at PE0 in order, and one length per completed sequence
  logic [1:0]  exp_data[$];
  int unsigned exp_len[$];
  int unsigned dptr = 0;
  int unsigned eptr = 0;
  int unsigned xptr = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (o_en) begin
        en_data.push_back(o_data);
        en_cyc.push_back(cyc);
      end
      if (o_rst) rst_cyc.push_back(cyc);
      if (o_seq_done) begin
        done_cyc.push_back(cyc);
        done_len.push_back(int'(o_seq_len));
        done_und.push_back(o_underrun);
      end
      if ((o_rst && o_en) || (!o_en && (o_data != 2'b00))) viol++;
      if (s_valid && !s_ready) stall++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] b, input logic l, input int gap);
    int guard;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    s_valid = 1'b1;
    s_base  = b;
    s_last  = l;
    guard   = 0;
    while (!s_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) chk("push_timeout", 32'(guard), 0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_base  = 2'b00;
  endtask

  task automatic send_seq(input int n, input int gap_max);
    logic [1:0] b;
    for (int i = 0; i < n; i++) begin
      b = 2'($urandom_range(0, 3));
      exp_data.push_back(b);
      push(b, (i == n - 1), int'($urandom_range(0, gap_max)));
    end
    exp_len.push_back(n);
  endtask

  task automatic wait_done(input int target);
    int guard;
    guard = 0;
    while (done_len.size() < target && guard < 6000) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    chk("done_wait", 32'(done_len.size() >= target), 1);
  endtask

  task automatic verify_seq(input string tag, input logic exp_und);
    int n;
    n = int'(exp_len[dptr]);
    chk({tag, "_en_count"}, 32'(en_data.size() >= eptr + n), 1);
    chk({tag, "_len"}, done_len[dptr], n);
    chk({tag, "_underrun"}, 32'(done_und[dptr]), 32'(exp_und));
    for (int i = 0; i < n; i++)
      chk({tag, "_data"}, 32'(en_data[eptr + i]), 32'(exp_data[xptr + i]));
    if (!exp_und)
      chk({tag, "_drain_gap"}, done_cyc[dptr] - en_cyc[eptr + n - 1], DRAIN_GAP);
    dptr++;
    eptr += n;
    xptr += n;
  endtask

  initial begin
    int guard;
    int unsigned rbase, sbase, nen;
    logic [1:0] b;

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_base  = 2'b00;
    s_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_o_rst", 32'(o_rst), 0);
    chk("rst_o_en", 32'(o_en), 0);
    chk("rst_o_data", 32'(o_data), 0);
    chk("rst_o_busy", 32'(o_busy), 0);
    chk("rst_o_seq_done", 32'(o_seq_done), 0);
    chk("rst_o_seq_len", 32'(o_seq_len), 0);
    chk("rst_o_underrun", 32'(o_underrun), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_s_ready", 32'(s_ready), 1);

    // Test 1: A,G,T,C back-to-back
    for (int i = 0; i < 4; i++) begin
      b = 2'(i);
      exp_data.push_back(b);
      push(b, (i == 3), 0);
    end
    exp_len.push_back(4);
    wait_done(1);
    chk("t1_rst_pulses", rst_cyc.size(), 2);
    chk("t1_rst_consec", rst_cyc[1] - rst_cyc[0], 1);
    chk("t1_en_after_rst", en_cyc[0] - rst_cyc[1], 1);
    chk("t1_en_consec", en_cyc[3] - en_cyc[0], 3);
    verify_seq("t1", 1'b0);
    repeat (3) @(negedge clk);
    chk("t1_len_hold", 32'(o_seq_len), 4);
    chk("t1_busy_idle", 32'(o_busy), 0);

    // Test 2: 64 bases with no last fill the FIFO, stream, then underrun
    for (int i = 0; i < 64; i++) begin
      b = 2'($urandom_range(0, 3));
      exp_data.push_back(b);
      push(b, 1'b0, 0);
    end
    guard = 0;
    while (!o_underrun && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("t2_underrun_seen", 32'(o_underrun), 1);
    chk("t2_en_before_drop", en_data.size() - eptr, 64);
    repeat (5) @(negedge clk);
    chk("t2_en_dropped", en_data.size() - eptr, 64);
    chk("t2_busy_discard", 32'(o_busy), 1);
    for (int i = 0; i < 3; i++) push(2'($urandom_range(0, 3)), (i == 2), 0);
    exp_len.push_back(64);
    wait_done(2);
    verify_seq("t2", 1'b1);
    chk("t2_discard_not_streamed", en_data.size(), eptr);
`ifdef SW_FEED_STATS_EN
    chk("stats_seq_count", 32'(o_seq_count), 2);
    chk("stats_underrun_count", 32'(o_underrun_count), 1);
`endif

    // Test 3: two 5-base sequences back-to-back
    rbase = rst_cyc.size();
    send_seq(5, 0);
    send_seq(5, 0);
    wait_done(int'(dptr) + 2);
    chk("t3_rst_pulses", rst_cyc.size() - rbase, 4);
    chk("t3_en_gap", 32'(en_cyc[eptr + 5] - en_cyc[eptr + 4] > 1), 1);
    verify_seq("t3a", 1'b0);
    verify_seq("t3b", 1'b0);

    // Test 4: s_valid held while the FIFO fills during drain and streaming
    sbase = stall;
    send_seq(int'($urandom_range(20, 30)), 0);
    send_seq(int'($urandom_range(55, 60)), 0);
    send_seq(int'($urandom_range(10, 20)), 0);
    wait_done(int'(dptr) + 3);
    chk("t4_backpressure", 32'(stall > sbase), 1);
    verify_seq("t4a", 1'b0);
    verify_seq("t4b", 1'b0);
    verify_seq("t4c", 1'b0);

    // Randomized sequences with random upstream gaps
    for (int s = 0; s < 5; s++) send_seq(int'($urandom_range(1, 40)), 2);
    wait_done(int'(dptr) + 5);
    for (int s = 0; s < 5; s++) verify_seq("rnd", 1'b0);

    // Test 5: reset pulse in the middle of streaming
    for (int i = 0; i < 20; i++) push(2'($urandom_range(0, 3)), (i == 19), 0);
    guard = 0;
    while (en_data.size() < eptr + 5 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("t5_stream_started", 32'(en_data.size() >= eptr + 5), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_o_en", 32'(o_en), 0);
    chk("t5_rst_o_rst", 32'(o_rst), 0);
    chk("t5_rst_o_data", 32'(o_data), 0);
    chk("t5_rst_o_busy", 32'(o_busy), 0);
    chk("t5_rst_o_seq_len", 32'(o_seq_len), 0);
    chk("t5_rst_o_underrun", 32'(o_underrun), 0);
    chk("t5_rst_s_ready", 32'(s_ready), 0);
    nen = en_data.size();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_release_s_ready", 32'(s_ready), 1);
    repeat (80) @(negedge clk);
    chk("t5_no_en_after", en_data.size(), nen);
    chk("t5_no_done", done_len.size(), dptr);
    chk("t5_idle_empty", 32'(o_busy), 0);
    eptr = en_data.size();
    send_seq(3, 1);
    wait_done(int'(dptr) + 1);
    verify_seq("t5_next", 1'b0);

    chk("protocol_violations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
